// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: ROM access port, redirect/halt controls and the decode handshake.
// The master modport is the fetch controller; the slave modport is its environment.
interface inst_fetch_ctrl_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  modport master (
    output rom_ce, rom_addr, out_valid, out_pc, out_inst, out_adel,
    input  rom_inst, redirect, redirect_pc, halt, out_ready
  );

  modport slave (
    input  rom_ce, rom_addr, out_valid, out_pc, out_inst, out_adel,
    output rom_inst, redirect, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the combinational instruction ROM and buffers
// {pc, inst, adel} entries in a prefetch FIFO drained by decode via valid/ready.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  inst_fetch_ctrl_if.master   bus
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StBoot, StFetch, StStopped} state_e;

  state_e state_q, state_d;

  logic [31:0]   pc_q, pc_d;
  logic [PtrW:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic        fifo_adel [DEPTH];

  logic        out_valid;
  logic        pop;
  logic        push;
  logic        space;
  logic        aligned;
  logic [31:0] push_inst;

  // Handshake, space and fetch qualification; redirect masks both push and pop.
  always_comb begin
    out_valid = (count_q != '0) && !bus.redirect;
    pop       = out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    space     = (count_q != FullCnt) || pop;
    aligned   = (pc_q[1:0] == 2'b00);
    push      = !bus.redirect && (state_q == StFetch) && !bus.halt && space;
    push_inst = aligned ? bus.rom_inst : 32'h0;
  end

  // Next-state for FSM, PC, occupancy and pointers.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (bus.redirect) begin
      state_d  = StFetch;
      pc_d     = bus.redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StBoot:    state_d = StFetch;
        StFetch: begin
          // A misaligned fetch leaves a single fault entry and parks the sequencer.
          if (push && !aligned) state_d = StStopped;
        end
        StStopped: state_d = StStopped;
        default:   state_d = StBoot;
      endcase

      if (push && aligned) pc_d = pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
        fifo_adel[i] <= 1'b0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr_q]   <= pc_q;
      fifo_inst[wr_ptr_q] <= push_inst;
      fifo_adel[wr_ptr_q] <= !aligned;
    end
  end

  // ROM is only enabled for aligned fetches; address always tracks the PC.
  assign bus.rom_ce    = push && aligned;
  assign bus.rom_addr  = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = fifo_pc[rd_ptr_q];
  assign bus.out_inst  = fifo_inst[rd_ptr_q];
  assign bus.out_adel  = fifo_adel[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: ROM word i holds 32'h1000_0000 + i.
// Inputs change 1 time unit after the rising edge; outputs are checked 4 units after it.
module tb_inst_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .RESET_PC (32'h0),
    .DEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model.
  assign bus.rom_inst = 32'h1000_0000 + {2'b00, bus.rom_addr[31:2]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  // Move from the drive point to the sample point of the same cycle.
  task automatic sample_pt();
    #3;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt        = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset values
    #4;
    chk("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("rst_rom_addr", bus.rom_addr, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_adel", 32'(bus.out_adel), 32'd0);

    // BOOT cycle after release
    drive_pt(); rst_n = 1'b1; sample_pt();
    chk("boot_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("boot_out_valid", 32'(bus.out_valid), 32'd0);
    // First ROM access
    drive_pt(); sample_pt();
    chk("first_rom_ce", 32'(bus.rom_ce), 32'd1);
    chk("first_rom_addr", bus.rom_addr, 32'h0);
    chk("first_out_valid", 32'(bus.out_valid), 32'd0);
    // Streaming at one per cycle
    for (int i = 0; i < 4; i++) begin
      drive_pt(); sample_pt();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_pc", bus.out_pc, 32'(4 * i));
      chk("stream_inst", bus.out_inst, 32'h1000_0000 + 32'(i));
      chk("stream_adel", 32'(bus.out_adel), 32'd0);
    end

    // Back-pressure: restart at 0 with out_ready low for 10 cycles
    drive_pt(); bus.redirect = 1'b1; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0; sample_pt();
    chk("bp_redir_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_redir_ce", 32'(bus.rom_ce), 32'd0);
    for (int k = 0; k < 9; k++) begin
      drive_pt(); bus.redirect = 1'b0; sample_pt();
      chk("bp_rom_ce", 32'(bus.rom_ce), (k < 4) ? 32'd1 : 32'd0);
    end
    chk("bp_held_addr", bus.rom_addr, 32'h10);
    chk("bp_head_pc", bus.out_pc, 32'h0);
    chk("bp_head_valid", 32'(bus.out_valid), 32'd1);
    // Release: fetch at 16 coincides with the first pop
    drive_pt(); bus.out_ready = 1'b1; sample_pt();
    chk("bp_resume_ce", 32'(bus.rom_ce), 32'd1);
    chk("bp_resume_addr", bus.rom_addr, 32'h10);
    chk("bp_pop0_pc", bus.out_pc, 32'h0);
    for (int j = 1; j <= 4; j++) begin
      drive_pt(); sample_pt();
      chk("bp_pop_pc", bus.out_pc, 32'(4 * j));
      chk("bp_pop_inst", bus.out_inst, 32'h1000_0000 + 32'(j));
    end

    // One halted pop leaves 3 entries, then redirect to 0x40
    drive_pt(); bus.halt = 1'b1; sample_pt();
    chk("h1_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("h1_head_pc", bus.out_pc, 32'h14);
    drive_pt(); bus.halt = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h40; sample_pt();
    chk("rd40_valid", 32'(bus.out_valid), 32'd0);
    chk("rd40_ce", 32'(bus.rom_ce), 32'd0);
    drive_pt(); bus.redirect = 1'b0; sample_pt();
    chk("rd40_empty", 32'(bus.out_valid), 32'd0);
    chk("rd40_fetch_addr", bus.rom_addr, 32'h40);
    chk("rd40_fetch_ce", 32'(bus.rom_ce), 32'd1);
    drive_pt(); sample_pt();
    chk("rd40_head_valid", 32'(bus.out_valid), 32'd1);
    chk("rd40_head_pc", bus.out_pc, 32'h40);
    chk("rd40_head_inst", bus.out_inst, 32'h1000_0010);

    // Misaligned redirect produces a single fault entry and stops fetching
    drive_pt(); bus.redirect = 1'b1; bus.redirect_pc = 32'h42; bus.out_ready = 1'b0; sample_pt();
    chk("rd42_valid", 32'(bus.out_valid), 32'd0);
    drive_pt(); bus.redirect = 1'b0; sample_pt();
    chk("adel_push_ce", 32'(bus.rom_ce), 32'd0);
    chk("adel_push_valid", 32'(bus.out_valid), 32'd0);
    drive_pt(); sample_pt();
    chk("adel_valid", 32'(bus.out_valid), 32'd1);
    chk("adel_pc", bus.out_pc, 32'h42);
    chk("adel_flag", 32'(bus.out_adel), 32'd1);
    chk("adel_inst", bus.out_inst, 32'h0);
    chk("adel_stop_ce", 32'(bus.rom_ce), 32'd0);
    drive_pt(); bus.out_ready = 1'b1; sample_pt();
    chk("adel_pop_valid", 32'(bus.out_valid), 32'd1);
    chk("adel_pop_ce", 32'(bus.rom_ce), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive_pt(); sample_pt();
      chk("stopped_valid", 32'(bus.out_valid), 32'd0);
      chk("stopped_ce", 32'(bus.rom_ce), 32'd0);
    end
    drive_pt(); bus.redirect = 1'b1; bus.redirect_pc = 32'h80; sample_pt();
    chk("rd80_ce", 32'(bus.rom_ce), 32'd0);
    drive_pt(); bus.redirect = 1'b0; sample_pt();
    chk("rd80_fetch_ce", 32'(bus.rom_ce), 32'd1);
    chk("rd80_fetch_addr", bus.rom_addr, 32'h80);
    drive_pt(); sample_pt();
    chk("rd80_head_pc", bus.out_pc, 32'h80);
    chk("rd80_head_inst", bus.out_inst, 32'h1000_0020);
    chk("rd80_head_adel", 32'(bus.out_adel), 32'd0);

    // PC wrap at the top of the address space
    drive_pt(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8; sample_pt();
    drive_pt(); bus.redirect = 1'b0; sample_pt();
    chk("wrap_fetch_addr", bus.rom_addr, 32'hFFFF_FFF8);
    drive_pt(); sample_pt();
    chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
    chk("wrap_inst0", bus.out_inst, 32'h4FFF_FFFE);
    drive_pt(); sample_pt();
    chk("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_inst1", bus.out_inst, 32'h4FFF_FFFF);
    chk("wrap_rom_addr", bus.rom_addr, 32'h0);
    drive_pt(); sample_pt();
    chk("wrap_pc2", bus.out_pc, 32'h0);
    chk("wrap_inst2", bus.out_inst, 32'h1000_0000);
    drive_pt(); sample_pt();
    chk("wrap_pc3", bus.out_pc, 32'h4);
    chk("wrap_inst3", bus.out_inst, 32'h1000_0001);

    // Halt for 3 cycles: FIFO drains, no fetches
    drive_pt(); bus.halt = 1'b1; sample_pt();
    chk("halt1_ce", 32'(bus.rom_ce), 32'd0);
    chk("halt1_valid", 32'(bus.out_valid), 32'd1);
    chk("halt1_pc", bus.out_pc, 32'h8);
    drive_pt(); sample_pt();
    chk("halt2_ce", 32'(bus.rom_ce), 32'd0);
    chk("halt2_valid", 32'(bus.out_valid), 32'd0);
    drive_pt(); sample_pt();
    chk("halt3_ce", 32'(bus.rom_ce), 32'd0);
    chk("halt3_addr", bus.rom_addr, 32'hC);
    drive_pt(); bus.halt = 1'b0; sample_pt();
    chk("unhalt_ce", 32'(bus.rom_ce), 32'd1);
    chk("unhalt_addr", bus.rom_addr, 32'hC);
    drive_pt(); sample_pt();
    chk("unhalt_head_pc", bus.out_pc, 32'hC);
    chk("unhalt_head_valid", 32'(bus.out_valid), 32'd1);

    // Asynchronous reset mid-stream, checked before any clock edge
    drive_pt(); rst_n = 1'b0; #1;
    chk("arst_rom_ce", 32'(bus.rom_ce), 32'd0);
    chk("arst_rom_addr", bus.rom_addr, 32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_pc", bus.out_pc, 32'h0);
    chk("arst_out_inst", bus.out_inst, 32'h0);
    chk("arst_out_adel", 32'(bus.out_adel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer placed in front of the combinational instruction ROM. It owns the PC, drives the ROM chip-enable and address, and buffers fetched words with their PCs in a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. Branch/exception redirects flush the FIFO, and misaligned fetch addresses are flagged without accessing the ROM.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.
DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rom_ce  output  1  ROM chip enable; 1 = access this cycle.
rom_addr  output  32  ROM byte address; the ROM indexes it as a word address.
rom_inst  input  32  ROM read data, valid combinationally in the same cycle as rom_ce/rom_addr.
redirect  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  32  new fetch PC, sampled when redirect=1.
halt  input  1  suspend new fetches; the FIFO keeps draining.
out_valid  output  1  FIFO head is valid.
out_ready  input  1  decode accepts the head this cycle.
out_pc  output  32  PC of the head entry.
out_inst  output  32  instruction of the head entry.
out_adel  output  1  head entry is a misaligned-fetch fault; out_inst=0.

Behaviour:
- State machine: BOOT, FETCH, STOPPED.
  - BOOT: entered on reset. Lasts exactly one cycle after rst_n deasserts, with rom_ce=0, then goes to FETCH.
  - FETCH: normal operation.
  - STOPPED: entered after a fault entry is pushed. No further fetches; left only by redirect, which goes to FETCH.
- Reset (async, any time, including mid-operation):
  - pc=RESET_PC, FIFO count=0, state=BOOT.
  - rom_ce=0, rom_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_adel=0.
- Fetch condition, when not redirecting: state==FETCH, halt=0, and space is available. Space means count<DEPTH, or count==DEPTH with a pop this cycle.
- Aligned fetch (pc[1:0]==0), when the fetch condition holds:
  - Same cycle: rom_ce=1, rom_addr=pc.
  - Push {pc, rom_inst, adel=0} into the FIFO.
  - pc <= pc+4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Misaligned fetch (pc[1:0]!=0), when the fetch condition holds:
  - rom_ce=0.
  - Push {pc, 32'h0, adel=1}.
  - pc is unchanged; state goes to STOPPED.
- When the fetch condition does not hold: rom_ce=0, rom_addr=pc.
- Pop: occurs when out_valid && out_ready. The entry leaves the FIFO at the clock edge.
- Outputs:
  - out_valid = (count!=0) && !redirect.
  - out_pc/out_inst/out_adel come from the head. When out_valid=0 they hold the last head values, with no requirement on them.
- Redirect (highest priority):
  - Same cycle: out_valid=0 and rom_ce=0; no pop and no push.
  - Next edge: count=0, pc=redirect_pc, state=FETCH, even from BOOT or STOPPED.
  - The first fetch from redirect_pc occurs in the following cycle.
  - A misaligned redirect_pc produces a fault entry in that following cycle.
- Simultaneous push and pop: count is unchanged. When full, a push is permitted only if a pop occurs in the same cycle.
- Empty FIFO: out_valid=0, and out_ready is ignored.
- halt: takes effect in the same cycle it is asserted (no push that cycle). Deasserting halt resumes fetching in the same cycle.
- Latency:
  - An instruction fetched in cycle N is presentable at out_* in cycle N+1.
  - First fetch after reset: the first clock edge after rst_n deasserts ends BOOT. The ROM is accessed in the following cycle, and out_valid=1 one cycle after that.
- Steady-state throughput is 1 instruction/cycle when out_ready is held at 1.
- Internal pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset release, ROM word i = 32'h1000_0000+i, RESET_PC=0, out_ready=1 -> BOOT cycle with rom_ce=0. Then out_pc=0,4,8,... with out_inst=32'h1000_0000, 32'h1000_0001, ... on consecutive cycles, and out_adel=0.
- out_ready=0 for 10 cycles -> exactly 4 pushes, then rom_ce=0 with pc held at 16. Raise out_ready -> entries pop in order 0,4,8,12, and fetch at 16 resumes in the same cycle as the first pop.
- FIFO holding 3 entries, redirect=1 with redirect_pc=32'h40 -> out_valid=0 that cycle, FIFO empty next cycle. Next head has out_pc=32'h40; no stale entry is ever delivered.
- redirect_pc=32'h42 -> one entry with out_pc=32'h42, out_adel=1, out_inst=0, followed by no further rom_ce pulses. A later redirect to 32'h80 resumes fetching.
- pc=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- halt=1 for 3 cycles in steady state -> rom_ce=0 and no pushes while out_valid drains. Assert rst_n=0 mid-stream -> all outputs go to reset values immediately, without waiting for a clock edge.
